clkdiv_multi: RTL and testbench

- Parametrised N-channel programmable clock-enable / divided-clock generator. Successor to the fixed single-ratio divider.
- Each channel has a runtime-writable divisor, a per-channel enable, and square or single-cycle pulse output mode.
- Optional cascading lets chains such as 50 MHz -> 1 MHz -> 1 kHz -> 1 Hz be built from one clock without derived clocks.
- Sits next to the PLL output; feeds LEDs, test outputs and downstream logic enables.

---
 rtl/clkdiv_multi.sv | 169 ++++++++++++++++
 tb/tb_clkdiv_multi.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_multi.sv
// ----------------------------------------------------------------------------
// clkdiv_multi
//
// N-channel programmable clock-enable / divided-clock generator running off a
// single system clock. Each channel owns a runtime-writable divisor, a run
// enable and a mode select:
//   mode = 0 : square wave on clkout_o, high floor(d/2) / low ceil(d/2) advances
//   mode = 1 : one-cycle strobe on tick_o every d advances
// A divisor of 0 behaves as 1. All outputs are registered.
//
// Optional feature (macro CLKDIV_CASCADE_EN):
//   Adds casc_i. A channel i > 0 with casc_i[i] = 1 advances only when channel
//   i-1 wraps in the same cycle, so chains divide by the product of their
//   divisors with no added latency. casc_i[0] has no effect.
//
// Parameters:
//   N_CH        number of channels (1..16)
//   WIDTH       divisor / counter width (2..32)
//   CH_W        width of wr_ch_i (>= clog2(N_CH), min 1)
//   DEFAULT_DIV divisor loaded into every channel at reset
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_i       synchronous active-high reset, overrides everything
//   en_i        per-channel run enable
//   mode_i      per-channel mode (0 square, 1 pulse)
//   wr_en_i     divisor write strobe
//   wr_ch_i     channel targeted by the write (out-of-range writes ignored)
//   wr_data_i   new divisor
//   sync_clr_i  clears every counter and output (divisors kept)
//   casc_i      cascade select (CLKDIV_CASCADE_EN only)
//   clkout_o    registered divided clock
//   tick_o      registered one-cycle strobe
// ----------------------------------------------------------------------------
module clkdiv_multi #(
    parameter int unsigned N_CH        = 3,
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned CH_W        = 2,
    parameter int unsigned DEFAULT_DIV = 50
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_CH-1:0]  en_i,
    input  logic [N_CH-1:0]  mode_i,
    input  logic             wr_en_i,
    input  logic [CH_W-1:0]  wr_ch_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             sync_clr_i,
`ifdef CLKDIV_CASCADE_EN
    input  logic [N_CH-1:0]  casc_i,
`endif
    output logic [N_CH-1:0]  clkout_o,
    output logic [N_CH-1:0]  tick_o
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] div_q [N_CH];
    logic [WIDTH-1:0] div_d [N_CH];
    logic [WIDTH-1:0] cnt_q [N_CH];
    logic [WIDTH-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  clkout_q, clkout_d;
    logic [N_CH-1:0]  tick_q, tick_d;

    // ------------------------------------------------------------------------
    // Per-channel advance / wrap
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] d_eff    [N_CH];
    logic [WIDTH-1:0] cnt_next [N_CH];  // counter after this cycle's advance
    logic [N_CH-1:0]  adv;
    logic [N_CH-1:0]  strobe;           // unregistered wrap strobe
    logic             prev_strobe;      // strobe of the previous channel in the chain
    logic [N_CH-1:0]  wr_hit;
    logic             wr_valid;

`ifdef CLKDIV_CASCADE_EN
    // Channel 0 has no upstream neighbour, so its cascade bit is meaningless.
    logic unused_casc0;
    assign unused_casc0 = casc_i[0];
`endif

    assign wr_valid = wr_en_i && (32'(wr_ch_i) < N_CH);

    // Channels are walked in order so a cascaded channel can see the strobe
    // of its lower neighbour within the same cycle.
    always_comb begin
        adv         = '0;
        strobe      = '0;
        prev_strobe = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            d_eff[i] = (div_q[i] == '0) ? WIDTH'(1) : div_q[i];
`ifdef CLKDIV_CASCADE_EN
            if ((i != 0) && casc_i[i]) begin
                adv[i] = en_i[i] & prev_strobe;
            end else begin
                adv[i] = en_i[i];
            end
`else
            adv[i] = en_i[i];
`endif
            strobe[i] = adv[i] && (cnt_q[i] == d_eff[i] - WIDTH'(1));
            if (!adv[i]) begin
                cnt_next[i] = cnt_q[i];
            end else if (strobe[i]) begin
                cnt_next[i] = '0;
            end else begin
                cnt_next[i] = cnt_q[i] + WIDTH'(1);
            end
            prev_strobe = strobe[i];
        end
    end

    // ------------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------------
    always_comb begin
        wr_hit   = '0;
        clkout_d = '0;
        tick_d   = '0;
        for (int i = 0; i < N_CH; i++) begin
            wr_hit[i] = wr_valid && (wr_ch_i == CH_W'(i));
            // A write updates div even when sync_clr masks its counter clear.
            div_d[i]  = wr_hit[i] ? wr_data_i : div_q[i];

            if (sync_clr_i || wr_hit[i]) begin
                cnt_d[i]    = '0;
                tick_d[i]   = 1'b0;
                clkout_d[i] = 1'b0;
            end else if (!en_i[i]) begin
                // Disabled: hold phase, silence outputs.
                cnt_d[i]    = cnt_q[i];
                tick_d[i]   = 1'b0;
                clkout_d[i] = 1'b0;
            end else begin
                cnt_d[i]    = cnt_next[i];
                tick_d[i]   = strobe[i] & mode_i[i];
                // Comparing the next count makes the registered output line up
                // with the counter value it reflects.
                clkout_d[i] = ~mode_i[i] & (cnt_next[i] < (d_eff[i] >> 1));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_CH; i++) begin
                div_q[i] <= WIDTH'(DEFAULT_DIV);
                cnt_q[i] <= '0;
            end
            clkout_q <= '0;
            tick_q   <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            clkout_q <= clkout_d;
            tick_q   <= tick_d;
        end
    end

    assign clkout_o = clkout_q;
    assign tick_o   = tick_q;

endmodule

// File: tb/tb_clkdiv_multi.sv
// ----------------------------------------------------------------------------
// tb_clkdiv_multi
//
// Self-checking bench for clkdiv_multi (N_CH=3, WIDTH=16, DEFAULT_DIV=50).
// Directed scenarios check against closed-form period patterns; a randomized
// run checks against a behavioural model that tracks each channel as a
// position modulo its effective divisor. Cascade scenarios are compiled only
// with CLKDIV_CASCADE_EN.
// ----------------------------------------------------------------------------
module tb_clkdiv_multi;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  en = '0;
    logic [2:0]  mode = '0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_ch = '0;
    logic [15:0] wr_data = '0;
    logic        sync_clr = 1'b0;
    logic [2:0]  casc = '0;
    logic [2:0]  clkout;
    logic [2:0]  tick;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int         m_div [N];
    int         m_pos [N];
    logic [2:0] exp_tick = '0;
    logic [2:0] exp_clk = '0;

    always #5 clk = ~clk;

    clkdiv_multi #(
        .N_CH        (3),
        .WIDTH       (16),
        .CH_W        (2),
        .DEFAULT_DIV (50)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .mode_i     (mode),
        .wr_en_i    (wr_en),
        .wr_ch_i    (wr_ch),
        .wr_data_i  (wr_data),
        .sync_clr_i (sync_clr),
`ifdef CLKDIV_CASCADE_EN
        .casc_i     (casc),
`endif
        .clkout_o   (clkout),
        .tick_o     (tick)
    );

    // Model: each channel sits at a position in [0, d); an advance moves it
    // one step around the ring, and completing the ring is a wrap.
    task automatic model_step();
        int   d [N];
        bit   adv [N];
        bit   wrap [N];
        bit   prev;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_div[i] = 50;
                m_pos[i] = 0;
            end
            exp_tick = '0;
            exp_clk  = '0;
            return;
        end
        prev = 1'b0;
        for (int i = 0; i < N; i++) begin
            d[i]   = (m_div[i] == 0) ? 1 : m_div[i];
            adv[i] = en[i];
`ifdef CLKDIV_CASCADE_EN
            if (i > 0 && casc[i]) adv[i] = en[i] && prev;
`endif
            wrap[i] = adv[i] && ((m_pos[i] + 1) % d[i] == 0);
            prev    = wrap[i];
        end
        for (int i = 0; i < N; i++) begin
            bit hit;
            hit = wr_en && (int'(wr_ch) == i);
            if (hit) m_div[i] = int'(wr_data);
            if (sync_clr || hit) begin
                m_pos[i]    = 0;
                exp_tick[i] = 1'b0;
                exp_clk[i]  = 1'b0;
            end else if (!en[i]) begin
                exp_tick[i] = 1'b0;
                exp_clk[i]  = 1'b0;
            end else begin
                if (adv[i]) m_pos[i] = (m_pos[i] + 1) % d[i];
                exp_tick[i] = wrap[i] && mode[i];
                exp_clk[i]  = !mode[i] && (m_pos[i] < d[i] / 2);
            end
        end
    endtask

    // One clock edge; inputs stay stable across the edge, outputs sampled 1 after.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic write_div(input int ch, input int val);
        wr_en   = 1'b1;
        wr_ch   = 2'(ch);
        wr_data = 16'(val);
        cycle();
        wr_en   = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; en = 3'b111; mode = 3'b000; sync_clr = 1'b0; casc = '0;
        for (int k = 0; k < 3; k++) begin
            // Reset must win over a write on the same edge.
            wr_en = (k == 2); wr_ch = 2'd0; wr_data = 16'd4;
            cycle();
            checks++;
            if (clkout !== 3'b000 || tick !== 3'b000) begin
                errors++;
                $display("FAIL reset_hold k=%0d clkout=%b tick=%b exp=000/000", k, clkout, tick);
            end
        end
        wr_en = 1'b0;
        rst   = 1'b0;
        // Default divisor 50: high while (k mod 50) < 25.
        for (int k = 1; k <= 100; k++) begin
            logic [2:0] e;
            cycle();
            e = ((k % 50) < 25) ? 3'b111 : 3'b000;
            checks++;
            if (clkout !== e || tick !== 3'b000) begin
                errors++;
                $display("FAIL reset_default_div k=%0d clkout=%b tick=%b exp=%b/000",
                         k, clkout, tick, e);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_square();
        int dl [3] = '{4, 5, 1};
        en = 3'b001; mode = 3'b000;
        foreach (dl[j]) begin
            write_div(0, dl[j]);
            checks++;
            if (clkout !== 3'b000 || tick !== 3'b000) begin
                errors++;
                $display("FAIL square_write_clear d=%0d clkout=%b tick=%b exp=000/000",
                         dl[j], clkout, tick);
            end
            for (int k = 1; k <= 12; k++) begin
                logic [2:0] e;
                cycle();
                e = {2'b00, (k % dl[j]) < (dl[j] / 2)};
                checks++;
                if (clkout !== e || tick !== 3'b000) begin
                    errors++;
                    $display("FAIL square d=%0d k=%0d clkout=%b tick=%b exp=%b/000",
                             dl[j], k, clkout, tick, e);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_pulse();
        int dl [2] = '{5, 0};
        en = 3'b010; mode = 3'b010;
        foreach (dl[j]) begin
            int de;
            de = (dl[j] == 0) ? 1 : dl[j];
            write_div(1, dl[j]);
            checks++;
            if (tick !== 3'b000) begin
                errors++;
                $display("FAIL pulse_write_clear d=%0d tick=%b exp=000", dl[j], tick);
            end
            for (int k = 1; k <= 15; k++) begin
                logic [2:0] e;
                cycle();
                e = {1'b0, (k % de) == 0, 1'b0};
                checks++;
                if (tick !== e || clkout !== 3'b000) begin
                    errors++;
                    $display("FAIL pulse d=%0d k=%0d tick=%b clkout=%b exp=%b/000",
                             dl[j], k, tick, clkout, e);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_rewrite();
        en = 3'b010; mode = 3'b010;
        write_div(1, 5);
        for (int k = 0; k < 3; k++) cycle();  // ch1 count now 3
        write_div(1, 7);
        for (int k = 1; k <= 14; k++) begin
            logic [2:0] e;
            // Out-of-range write at edge 8 must not disturb anything.
            wr_en = (k == 8); wr_ch = 2'd3; wr_data = 16'd2;
            cycle();
            e = {1'b0, (k == 7 || k == 14), 1'b0};
            checks++;
            if (tick !== e) begin
                errors++;
                $display("FAIL rewrite k=%0d tick=%b exp=%b", k, tick, e);
            end
        end
        wr_en = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_sync_clr();
        en = 3'b101; mode = 3'b101;
        write_div(0, 6);
        cycle();
        write_div(2, 3);
        cycle(); cycle();
        sync_clr = 1'b1;
        cycle();
        sync_clr = 1'b0;
        checks++;
        if (tick !== 3'b000 || clkout !== 3'b000) begin
            errors++;
            $display("FAIL sync_clr_outputs tick=%b clkout=%b exp=000/000", tick, clkout);
        end
        for (int k = 1; k <= 12; k++) begin
            logic [2:0] e;
            cycle();
            e = {(k % 3) == 0, 1'b0, (k % 6) == 0};
            checks++;
            if (tick !== e) begin
                errors++;
                $display("FAIL sync_align k=%0d tick=%b exp=%b", k, tick, e);
            end
        end
        // Enable hold: ch0 runs 2 advances, pauses 4 edges, then resumes.
        sync_clr = 1'b1;
        cycle();
        sync_clr = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            logic [2:0] e;
            en[0] = !(k >= 3 && k <= 6);
            cycle();
            e = {(k % 3) == 0, 1'b0, k == 10};
            checks++;
            if (tick !== e) begin
                errors++;
                $display("FAIL enable_hold k=%0d tick=%b exp=%b", k, tick, e);
            end
        end
        en = 3'b101;
    endtask

`ifdef CLKDIV_CASCADE_EN
    // ------------------------------------------------------------------------
    task automatic test_cascade();
        en = 3'b011; mode = 3'b011; casc = 3'b000;
        write_div(0, 4);
        write_div(1, 3);
        casc = 3'b010; sync_clr = 1'b1;
        cycle();
        sync_clr = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            logic [2:0] e;
            cycle();
            e = {1'b0, (k % 12) == 0, (k % 4) == 0};
            checks++;
            if (tick !== e) begin
                errors++;
                $display("FAIL cascade_on k=%0d tick=%b exp=%b", k, tick, e);
            end
        end
        casc = 3'b000; sync_clr = 1'b1;
        cycle();
        sync_clr = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            logic [2:0] e;
            cycle();
            e = {1'b0, (k % 3) == 0, (k % 4) == 0};
            checks++;
            if (tick !== e) begin
                errors++;
                $display("FAIL cascade_off k=%0d tick=%b exp=%b", k, tick, e);
            end
        end
    endtask
`endif

    // ------------------------------------------------------------------------
    task automatic test_random();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 600; k++) begin
            en       = 3'($urandom | $urandom);
            if ($urandom_range(0, 15) == 0) mode = 3'($urandom);
            casc     = 3'($urandom);
            wr_en    = ($urandom_range(0, 7) == 0);
            wr_ch    = 2'($urandom_range(0, 3));
            wr_data  = 16'($urandom_range(0, 9));
            sync_clr = ($urandom_range(0, 29) == 0);
            rst      = ($urandom_range(0, 249) == 0);
            cycle();
            checks++;
            if (tick !== exp_tick || clkout !== exp_clk) begin
                errors++;
                $display("FAIL random k=%0d tick=%b clkout=%b exp=%b/%b",
                         k, tick, clkout, exp_tick, exp_clk);
            end
        end
        rst = 1'b0; wr_en = 1'b0; sync_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_square();
        test_pulse();
        test_rewrite();
        test_sync_clr();
`ifdef CLKDIV_CASCADE_EN
        test_cascade();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
